// File: rtl/cal_ddssweep.sv
// ---------------------------------------------------------------------------
// cal_ddssweep
//
// Purpose:
//   Steps a downstream clock divider through a list of divisors, from a start
//   divisor towards a stop divisor, in fixed increments. Every divisor is
//   presented one cycle ahead of a two-cycle load strobe. It is then held for a
//   programmable dwell time before the next divisor is chosen. The last step
//   is clamped to the stop divisor, so the sweep always ends exactly on it.
//
// Ports:
//   i_clkin     system clock, every flop runs on its rising edge
//   i_reset     synchronous active-high reset
//   i_start     sweep request, level-sampled while idle
//   i_abort     cancels a running sweep, sampled every cycle
//   i_startdiv  first divisor of the sweep (0 is promoted to 1)
//   i_stopdiv   last divisor of the sweep (0 is promoted to 1)
//   i_stepdiv   divisor increment magnitude (0 is promoted to 1)
//   i_dwell     cycles each divisor is held after its load strobe (0 -> 1)
//   o_divcount  divisor for the downstream divider, registered
//   o_load      latch strobe for the downstream divider, registered
//   o_busy      high whenever a sweep is in progress, registered
//   o_done      single-cycle pulse when a sweep completes normally
// ---------------------------------------------------------------------------
module cal_ddssweep (
  input  logic       i_clkin,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [5:0] i_startdiv,
  input  logic [5:0] i_stopdiv,
  input  logic [5:0] i_stepdiv,
  input  logic [7:0] i_dwell,
  output logic [5:0] o_divcount,
  output logic       o_load,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_DWELL = 3'd3,
    S_DONE  = 3'd4
  } sweepState_t;

  sweepState_t r_state;
  sweepState_t w_nextState;

  // Sweep parameters are captured once at start so that input changes
  // during a sweep cannot disturb it.
  logic [5:0] r_divCount;
  logic [5:0] r_stopDiv;
  logic [5:0] r_stepDiv;
  logic [7:0] r_dwell;
  logic       r_dirDown;

  // Shared down-counter: remaining LOAD cycles, then remaining DWELL cycles.
  logic [7:0] r_cnt;

  logic       r_load;
  logic       r_busy;
  logic       r_done;

  logic [5:0] w_startSel;
  logic [5:0] w_stopSel;
  logic [5:0] w_stepSel;
  logic [7:0] w_dwellSel;
  logic [6:0] w_sum;
  logic [6:0] w_diff;
  logic [6:0] w_stop7;
  logic [5:0] w_stepNext;
  logic [5:0] w_nextDivCount;
  logic [7:0] w_nextCnt;
  logic       w_capture;

  // Zero is not a usable divisor, step or dwell. Promote each of them to 1
  // before capture, so the sweep logic never sees a zero.
  always_comb begin
    w_startSel = (i_startdiv == 6'd0) ? 6'd1 : i_startdiv;
    w_stopSel  = (i_stopdiv  == 6'd0) ? 6'd1 : i_stopdiv;
    w_stepSel  = (i_stepdiv  == 6'd0) ? 6'd1 : i_stepdiv;
    w_dwellSel = (i_dwell    == 8'd0) ? 8'd1 : i_dwell;
  end

  // Next divisor of the sweep. The arithmetic is one bit wider than the
  // divisor. In that extra bit, a carry past 63 going up, or a borrow below
  // zero going down, shows up as bit 6 being set.
  // Any result that reaches or passes the stop divisor is clamped to the stop
  // divisor. That clamp also covers overflow and underflow, because stop
  // always lies in 1..63.
  always_comb begin
    w_sum   = {1'b0, r_divCount} + {1'b0, r_stepDiv};
    w_diff  = {1'b0, r_divCount} - {1'b0, r_stepDiv};
    w_stop7 = {1'b0, r_stopDiv};
    if (r_dirDown) begin
      if (w_diff[6] || (w_diff <= w_stop7)) begin
        w_stepNext = r_stopDiv;
      end else begin
        w_stepNext = w_diff[5:0];
      end
    end else begin
      if (w_sum >= w_stop7) begin
        w_stepNext = r_stopDiv;
      end else begin
        w_stepNext = w_sum[5:0];
      end
    end
  end

  // Next-state logic.
  // Sequence per divisor: one SETUP cycle, then two LOAD cycles, then
  // r_dwell DWELL cycles. The divisor only changes when DWELL hands over to
  // SETUP, so it is never moving while load is high or just before.
  // Abort overrides everything once a sweep is running. It leaves the
  // divisor untouched, so the downstream divider keeps its current setting.
  always_comb begin
    w_nextState    = r_state;
    w_nextDivCount = r_divCount;
    w_nextCnt      = r_cnt;
    w_capture      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_capture      = 1'b1;
          w_nextDivCount = w_startSel;
          w_nextState    = S_SETUP;
        end
      end

      S_SETUP: begin
        w_nextState = S_LOAD;
        w_nextCnt   = 8'd1;
      end

      S_LOAD: begin
        if (r_cnt == 8'd0) begin
          w_nextState = S_DWELL;
          w_nextCnt   = r_dwell - 8'd1;
        end else begin
          w_nextCnt = r_cnt - 8'd1;
        end
      end

      S_DWELL: begin
        if (r_cnt == 8'd0) begin
          if (r_divCount == r_stopDiv) begin
            w_nextState = S_DONE;
          end else begin
            w_nextDivCount = w_stepNext;
            w_nextState    = S_SETUP;
          end
        end else begin
          w_nextCnt = r_cnt - 8'd1;
        end
      end

      S_DONE: begin
        w_nextState = S_IDLE;
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase

    if ((r_state != S_IDLE) && i_abort) begin
      w_nextState    = S_IDLE;
      w_nextDivCount = r_divCount;
      w_nextCnt      = r_cnt;
    end
  end

  // State, parameter and output registers.
  // The outputs are decoded from the next state, so they line up exactly with
  // the state register and come straight out of flops. A reset or an abort
  // therefore drops load on the same edge that leaves the LOAD state.
  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_divCount <= 6'd1;
      r_stopDiv  <= 6'd0;
      r_stepDiv  <= 6'd0;
      r_dwell    <= 8'd0;
      r_dirDown  <= 1'b0;
      r_cnt      <= 8'd0;
      r_load     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_divCount <= w_nextDivCount;
      r_cnt      <= w_nextCnt;
      if (w_capture) begin
        r_stopDiv <= w_stopSel;
        r_stepDiv <= w_stepSel;
        r_dwell   <= w_dwellSel;
        r_dirDown <= (w_stopSel < w_startSel);
      end
      r_load <= (w_nextState == S_LOAD);
      r_busy <= (w_nextState != S_IDLE);
      r_done <= (w_nextState == S_DONE);
    end
  end

  assign o_divcount = r_divCount;
  assign o_load     = r_load;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_cal_ddssweep.sv
// ---------------------------------------------------------------------------
// tb_cal_ddssweep
//
// Purpose:
//   Self-checking bench for cal_ddssweep.
//   A table of sweep vectors lists the inputs together with the expected
//   divisor sequence, the spacing between load strobes and the number of busy
//   cycles. Expected divisors are queued when a sweep is started and popped
//   whenever a load strobe rises.
//   Hand-written sequences cover reset, abort, start/abort together and
//   start pulses arriving mid-sweep.
// ---------------------------------------------------------------------------
module tb_cal_ddssweep;

  localparam int NV = 8;
  localparam int MAX_CYC = 300;

  typedef struct {
    logic [5:0] startDiv;
    logic [5:0] stopDiv;
    logic [5:0] stepDiv;
    logic [7:0] dwell;
    int         nDiv;
    int         spacing;
    int         busyCycles;
  } vec_t;

  logic       clkin = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [5:0] startdiv;
  logic [5:0] stopdiv;
  logic [5:0] stepdiv;
  logic [7:0] dwell;
  logic [5:0] divcount;
  logic       load;
  logic       busy;
  logic       done;

  int   checks = 0;
  int   errors = 0;
  int   expQ[$];
  vec_t vecs[NV];
  int   expDivs[NV][16];

  always #5 clkin = ~clkin;

  cal_ddssweep dut (
    .i_clkin    (clkin),
    .i_reset    (reset),
    .i_start    (start),
    .i_abort    (abort),
    .i_startdiv (startdiv),
    .i_stopdiv  (stopdiv),
    .i_stepdiv  (stepdiv),
    .i_dwell    (dwell),
    .o_divcount (divcount),
    .o_load     (load),
    .o_busy     (busy),
    .o_done     (done)
  );

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to just after the next rising edge.
  // Inputs are driven and outputs sampled here, well away from the edge.
  task automatic tick;
    @(posedge clkin);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic driveStart(input logic [5:0] sd, input logic [5:0] pd,
                            input logic [5:0] st, input logic [7:0] dw);
    startdiv = sd;
    stopdiv  = pd;
    stepdiv  = st;
    dwell    = dw;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Start a table sweep and queue the divisors it should present.
  task automatic applyStimulus(input int idx);
    expQ.delete();
    for (int k = 0; k < vecs[idx].nDiv; k++) begin
      expQ.push_back(expDivs[idx][k]);
    end
    driveStart(vecs[idx].startDiv, vecs[idx].stopDiv, vecs[idx].stepDiv, vecs[idx].dwell);
  endtask

  // Watch one sweep from its SETUP cycle until busy drops. The checks cover:
  //   - the divisor seen on every load rise,
  //   - load pulse widths and the spacing between load rises,
  //   - that load is quiet around divisor changes,
  //   - the busy length and the done count.
  // With disturb set, a start pulse and new inputs are thrown in mid-sweep.
  task automatic observeSweep(input string name, input int spacing, input int busyExp,
                              input int lastDiv, input bit disturb);
    int   busyCnt;
    int   doneCnt;
    int   loadRun;
    int   lastRise;
    int   cyc;
    logic prevLoad;
    logic [5:0] prevDiv;
    busyCnt  = 0;
    doneCnt  = 0;
    loadRun  = 0;
    lastRise = -1;
    cyc      = 0;
    prevLoad = 1'b0;
    prevDiv  = divcount;
    while (busy && (cyc < MAX_CYC)) begin
      busyCnt++;
      if (done) doneCnt++;
      if (load && !prevLoad) begin
        if (lastRise >= 0) checkOutput({name, "_spacing"}, cyc - lastRise, spacing);
        lastRise = cyc;
        if (expQ.size() == 0) begin
          checkOutput({name, "_extraLoad"}, int'(divcount), -1);
        end else begin
          checkOutput({name, "_div"}, int'(divcount), expQ.pop_front());
        end
      end
      if (load) begin
        loadRun++;
      end else if (prevLoad) begin
        checkOutput({name, "_loadWidth"}, loadRun, 2);
        loadRun = 0;
      end
      if (divcount != prevDiv) begin
        checkOutput({name, "_loadQuiet"}, int'({prevLoad, load}), 0);
      end
      if (disturb && cyc == 2) begin
        startdiv = 6'd50;
        stopdiv  = 6'd60;
        stepdiv  = 6'd1;
        dwell    = 8'd9;
        start    = 1'b1;
      end
      if (disturb && cyc == 4) start = 1'b0;
      prevLoad = load;
      prevDiv  = divcount;
      tick();
      cyc++;
    end
    checkOutput({name, "_ended"}, int'(busy), 0);
    checkOutput({name, "_busyCycles"}, busyCnt, busyExp);
    checkOutput({name, "_doneCount"}, doneCnt, 1);
    checkOutput({name, "_pendingDivs"}, expQ.size(), 0);
    expQ.delete();
    checkOutput({name, "_idleLoad"}, int'(load), 0);
    checkOutput({name, "_idleDone"}, int'(done), 0);
    tick();
    checkOutput({name, "_idleHold"}, int'(divcount), lastDiv);
  endtask

  initial begin
    int   rises;
    int   doneSeen;
    int   busySeen;
    logic prevLoad;

    // Sweep vectors: inputs, number of divisors, load-rise spacing
    // (dwell + SETUP + two LOAD cycles), total busy cycles.
    vecs[0] = '{6'd4,  6'd8,  6'd2,  8'd3, 3,  6, 19};
    vecs[1] = '{6'd10, 6'd3,  6'd4,  8'd1, 3,  4, 13};
    vecs[2] = '{6'd0,  6'd0,  6'd0,  8'd0, 1,  4,  5};
    vecs[3] = '{6'd5,  6'd5,  6'd3,  8'd2, 1,  5,  6};
    vecs[4] = '{6'd60, 6'd63, 6'd10, 8'd1, 2,  4,  9};
    vecs[5] = '{6'd2,  6'd0,  6'd5,  8'd2, 2,  5, 11};
    vecs[6] = '{6'd1,  6'd10, 6'd0,  8'd0, 10, 4, 41};
    vecs[7] = '{6'd9,  6'd20, 6'd5,  8'd4, 4,  7, 29};
    expDivs[0] = '{4, 6, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expDivs[1] = '{10, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expDivs[2] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expDivs[3] = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expDivs[4] = '{60, 63, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expDivs[5] = '{2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expDivs[6] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 0, 0, 0, 0, 0};
    expDivs[7] = '{9, 14, 19, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset with start and abort both high: reset must win.
    reset    = 1'b1;
    start    = 1'b1;
    abort    = 1'b1;
    startdiv = 6'd7;
    stopdiv  = 6'd9;
    stepdiv  = 6'd1;
    dwell    = 8'd2;
    tick();
    tick();
    checkOutput("resetDiv",  int'(divcount), 1);
    checkOutput("resetLoad", int'(load), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetDone", int'(done), 0);
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    checkOutput("idleAfterReset", int'(busy), 0);

    // Table-driven sweeps.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(i);
      checkOutput($sformatf("vec%0d_setupBusy", i), int'(busy), 1);
      checkOutput($sformatf("vec%0d_setupLoad", i), int'(load), 0);
      observeSweep($sformatf("vec%0d", i), vecs[i].spacing, vecs[i].busyCycles,
                   expDivs[i][vecs[i].nDiv - 1], 1'b0);
    end

    // Abort during the second load cycle of step 2.
    driveStart(6'd4, 6'd8, 6'd2, 8'd3);
    rises    = 0;
    prevLoad = 1'b0;
    for (int c = 0; c < MAX_CYC; c++) begin
      if (load && !prevLoad) rises++;
      if (load && prevLoad && rises == 2) break;
      prevLoad = load;
      tick();
    end
    checkOutput("abortReachedLoad2", rises, 2);
    checkOutput("abortDivBefore", int'(divcount), 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abortLoad", int'(load), 0);
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortDone", int'(done), 0);
    checkOutput("abortDivHeld", int'(divcount), 6);
    doneSeen = 0;
    busySeen = 0;
    for (int c = 0; c < 25; c++) begin
      if (done) doneSeen = 1;
      if (busy) busySeen = 1;
      tick();
    end
    checkOutput("abortNoDone", doneSeen, 0);
    checkOutput("abortStaysIdle", busySeen, 0);

    // Reset during DWELL of step 1 with start held high, then restart.
    startdiv = 6'd4;
    stopdiv  = 6'd8;
    stepdiv  = 6'd2;
    dwell    = 8'd3;
    start    = 1'b1;
    tick();
    prevLoad = 1'b0;
    for (int c = 0; c < MAX_CYC; c++) begin
      if (!load && prevLoad) break;
      prevLoad = load;
      tick();
    end
    checkOutput("rstInDwellBusy", int'(busy), 1);
    reset = 1'b1;
    tick();
    checkOutput("rstMidDiv",  int'(divcount), 1);
    checkOutput("rstMidLoad", int'(load), 0);
    checkOutput("rstMidBusy", int'(busy), 0);
    checkOutput("rstMidDone", int'(done), 0);
    tick();
    checkOutput("rstHeldBusy", int'(busy), 0);
    reset = 1'b0;
    tick();
    checkOutput("restartBusy", int'(busy), 1);
    checkOutput("restartDiv", int'(divcount), 4);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("restartAbortBusy", int'(busy), 0);

    // Start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    checkOutput("startAbortBusy1", int'(busy), 0);
    tick();
    checkOutput("startAbortBusy2", int'(busy), 0);
    checkOutput("startAbortDiv", int'(divcount), 4);
    start = 1'b0;
    abort = 1'b0;
    tick();

    // Start pulse and input changes mid-sweep must not disturb it.
    applyStimulus(1);
    observeSweep("busyStart", vecs[1].spacing, vecs[1].busyCycles, 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cal_ddssweep.md
CAL_DDSSWEEP -- requirements
Module: cal_ddssweep

Interface
REQ-001 clkin  input  1  system clock; all logic on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clkin.
REQ-003 start  input  1  sweep request, level-sampled in IDLE only.
REQ-004 abort  input  1  terminate sweep, sampled every cycle.
REQ-005 startdiv  input  6  first divisor of sweep.
REQ-006 stopdiv  input  6  last divisor of sweep.
REQ-007 stepdiv  input  6  divisor increment magnitude.
REQ-008 dwell  input  8  clkin cycles to hold each divisor after its load pulse.
REQ-009 divcount  output  6  divisor presented to downstream clock divider, registered.
REQ-010 load  output  1  latch strobe to downstream divider, registered, active high.
REQ-011 busy  output  1  high in every state except IDLE, registered.
REQ-012 done  output  1  one-cycle pulse on normal sweep completion, registered.

Function
REQ-013 States: IDLE, SETUP, LOAD, DWELL, DONE; one-hot or binary is free, but behaviour shall match cycle-exactly.
REQ-014 IDLE: on edge with start=1 and abort=0, capture stopdiv, stepdiv, dwell, direction; divcount <= startdiv; go SETUP.
REQ-015 Direction = down when stopdiv < startdiv, else up; fixed for the whole sweep.
REQ-016 Divisor 0 on startdiv or stopdiv shall be replaced by 1 at capture; stepdiv 0 shall be treated as 1; dwell 0 shall be treated as 1.
REQ-017 SETUP: exactly 1 cycle, load=0, divcount stable; then LOAD.
REQ-018 LOAD: load=1 for exactly 2 consecutive cycles, divcount unchanged; then DWELL.
REQ-019 DWELL: load=0 for exactly dwell (captured) cycles, divcount unchanged.
REQ-020 End of DWELL: if divcount == captured stop, go DONE; else divcount <= next divisor, go SETUP.
REQ-021 Next divisor: computed 7-bit; up = divcount+step, down = divcount-step; if result passes or equals stop (or underflows below 1 / exceeds 63) the value shall be stop.
REQ-022 DONE: done=1, busy=1 for 1 cycle; then IDLE with busy=0, done=0.
REQ-023 divcount shall hold its last value in IDLE (downstream keeps running last divisor).
REQ-024 abort=1 in any non-IDLE state: next state IDLE, load=0, busy=0, done never pulses, divcount held.
REQ-025 abort and start both high in IDLE: abort wins, stay IDLE.
REQ-026 start high while busy: ignored; input changes on startdiv/stopdiv/stepdiv/dwell during sweep: no effect.
REQ-027 startdiv == stopdiv: single SETUP/LOAD/DWELL pass then DONE.
REQ-028 load shall never be high in the same cycle divcount changes, nor in the cycle after.

Reset
REQ-029 reset=1 on rising clkin: state IDLE, divcount=1, load=0, busy=0, done=0, captured registers cleared; overrides start and abort.
REQ-030 reset mid-sweep (including during LOAD) shall drop load on the same edge with no further pulse.

Verification
REQ-031 start=1 startdiv=4 stopdiv=8 stepdiv=2 dwell=3 -> divcount 4,6,8; per step SETUP 1, load 2 cycles, dwell 3; done pulse 1 cycle after third dwell; total busy 19 cycles.
REQ-032 startdiv=10 stopdiv=3 stepdiv=4 dwell=1 -> divcount 10,6,3 (clamped), down direction, done once.
REQ-033 startdiv=0 stopdiv=0 stepdiv=0 dwell=0 -> divcount 1, one 2-cycle load, dwell 1, done; busy 5 cycles.
REQ-034 abort asserted during second LOAD cycle of step 2 -> next cycle IDLE, load=0, busy=0, done stays 0, divcount holds step-2 value.
REQ-035 reset asserted during DWELL of step 1, start held high -> divcount=1, all outputs 0; after reset release with start=1, sweep restarts from startdiv.
REQ-036 start and abort high together in IDLE; start pulse while busy -> no sweep begun, resp. current sweep unaffected.
